pixel_band_deserializer: RTL and testbench
==========================================

Name: pixel_band_deserializer

Overview:
Gathers a serial stream of hyperspectral band samples, one per transfer, into a full pixel vector of NUM_BANDS samples. It presents that vector downstream with a valid/ready handshake. It sits directly upstream of the pixel vector register bank, producing the per-slot load strobes and the assembled vector consumed by the LCMV dot-product stage.

Parameters:
WIDTH, 16, bits per band sample
NUM_BANDS, 8, bands per pixel (>=2)
CNT_WIDTH, 16, width of emitted-pixel counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
clear  input  1  synchronous flush of partial/held pixel
in_data  input  WIDTH  band sample
in_valid  input  1  in_data valid
in_ready  output  1  block accepts a sample this cycle
out_data  output  NUM_BANDS*WIDTH  pixel vector; band k at [k*WIDTH +: WIDTH]
out_valid  output  1  out_data holds a complete pixel
out_ready  input  1  downstream accepts pixel
pixel_cnt  output  CNT_WIDTH  pixels emitted, modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst low, async): state=FILL, band index=0, out_valid=0, out_data=0, pixel_cnt=0. in_ready=0 while rst is low.
- Accept = in_valid && in_ready. Sample k (0-based since last pixel boundary) is written to slot k; index increments per accept.
- States:
  - FILL: in_ready=1. On accept of band NUM_BANDS-1, go to FULL; index wraps to 0; out_valid=1 from the next cycle (latency 1).
  - FULL: in_ready=0; out_data stable; in_valid ignored. On out_valid && out_ready, go to FILL; out_valid=0 and in_ready=1 from the next cycle; pixel_cnt+1.
- pixel_cnt wraps from 2^CNT_WIDTH-1 to 0.
- out_data is not cleared after a handshake; slots are overwritten individually as new bands arrive.
- out_data is meaningful only while out_valid=1.
- clear=1:
  - Next state is FILL, index=0, out_valid=0.
  - A held pixel is dropped and pixel_cnt is unchanged.
  - clear has priority over a same-cycle input accept or output handshake: neither takes effect.
- Reset mid-pixel: the partial pixel is discarded; the stream restarts at band 0.
- in_valid held with in_ready=0: no state change. Upstream must hold its data.

Optional Feature:
Macro DESER_PIPELINE_EN.
- Defined: two banks (fill bank, output bank).
  - FILL continues into the fill bank while the output bank is valid.
  - On the last band, the fill bank transfers to the output bank if the output bank is empty or handshaking this cycle. The new pixel is valid the next cycle, with no bubble.
  - Otherwise the completed fill bank waits, and in_ready=0 until the output handshake.
  - Sustained throughput: one band per cycle with out_ready=1.
  - clear flushes both banks.
- Undefined: single bank, behaving exactly as the FILL/FULL description above, with one bubble cycle per pixel on the input side.

Decomposition:
- Package deser_pkg holds:
  - the state enum typedef (FILL, FULL, plus PEND_FULL when pipelined)
  - the index width function/constant $clog2(NUM_BANDS)
  - the slot-select helper
- Natural sub-module: the team's existing load-enabled register. Instantiate one per band slot, with load driven by the decoded accept strobe for that slot.

Test Plan:
(WIDTH=8, NUM_BANDS=4, CNT_WIDTH=2)
- Reset release, then bands 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=0 -> out_valid=1 one cycle after 0x44; out_data=0x44332211; in_ready=0.
- From the held pixel, pulse out_ready -> out_valid=0 and in_ready=1 next cycle; pixel_cnt=1. Send 4 more pixels -> pixel_cnt wraps 3->0.
- Feed 2 bands, assert clear together with in_valid on band 3 -> band discarded. Next 4 bands 0xA1..0xA4 -> out_data=0xA4A3A2A1.
- Assert rst low after 3 bands -> out_valid=0, pixel_cnt=0 immediately (async). After release, 4 fresh bands form one pixel.
- in_valid toggling randomly, out_ready held 1 -> every pixel equals its 4 accepted samples in order; no sample is lost or duplicated.
- With DESER_PIPELINE_EN: continuous in_valid=1, out_ready=1 -> in_ready never drops, out_valid pulses every 4 cycles. With out_ready=0 -> in_ready drops after the 8th band.

Source files
------------

// File: rtl/deser_pkg.sv
// Shared types and helpers for the pixel band deserializer.
// Optional two-bank pipelining is enabled by defining DESER_PIPELINE_EN.
package deser_pkg;

`ifdef DESER_PIPELINE_EN
  typedef enum logic [1:0] {
    FILL,
    FULL,
    PEND_FULL
  } state_t;
`else
  typedef enum logic [1:0] {
    FILL,
    FULL
  } state_t;
`endif

  function automatic int unsigned idx_w(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic slot_sel(
    input int unsigned idx,
    input int unsigned slot
  );
    return idx == slot;
  endfunction

endpackage

// File: rtl/pixel_band_deserializer_reg.sv
// Load-enabled register holding one band slot.
// Ports: clk, rst (async active-low), load, d, q.
module pixel_band_deserializer_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pixel_band_deserializer.sv
// Serial band samples in, full pixel vector out (valid/ready both sides).
// Ports: clk, rst (async active-low), clear, in_data/in_valid/in_ready,
// out_data/out_valid/out_ready, pixel_cnt. Macro: DESER_PIPELINE_EN.
module pixel_band_deserializer
  import deser_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int NUM_BANDS = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_BANDS*WIDTH-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CNT_WIDTH-1:0]       pixel_cnt
);

  localparam int IW = idx_w(NUM_BANDS);
  localparam logic [IW-1:0] LAST = IW'(NUM_BANDS - 1);

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic            accept;
  logic            hs;
  logic            last;
  logic [NUM_BANDS-1:0] load;

  assign accept = in_valid && in_ready;
  assign hs     = out_valid && out_ready;
  assign last   = accept && (idx == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      idx       <= '0;
      pixel_cnt <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (!clear && hs) begin
        pixel_cnt <= pixel_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_BANDS; k++) begin
      load[k] = accept && !clear
                && slot_sel(32'(idx), k);
    end
  end

`ifdef DESER_PIPELINE_EN

  logic [WIDTH-1:0] fill_q [NUM_BANDS];
  logic             xfer;

  assign in_ready  = rst && (state != PEND_FULL);
  assign out_valid = (state != FILL);

  // Fill bank moves to the output bank on the last band when the
  // output bank is free, or when a waiting bank sees its handshake.
  assign xfer = !clear
    && ((last && ((state == FILL) || out_ready))
        || ((state == PEND_FULL) && out_ready));

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (clear) begin
      state_nx = FILL;
      idx_nx   = '0;
    end else begin
      if (accept) begin
        idx_nx = last ? '0 : idx + 1'b1;
      end
      unique case (state)
        FILL: begin
          if (last) state_nx = FULL;
        end
        FULL: begin
          if (last) begin
            state_nx = out_ready ? FULL : PEND_FULL;
          end else if (out_ready) begin
            state_nx = FILL;
          end
        end
        PEND_FULL: begin
          if (out_ready) state_nx = FULL;
        end
        default: state_nx = FILL;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_slot
    logic [WIDTH-1:0] od;

    // The last band bypasses the fill bank unless it is already there.
    if (k == NUM_BANDS - 1) begin : g_byp
      assign od = (state == PEND_FULL) ? fill_q[k] : in_data;
    end else begin : g_fill
      assign od = fill_q[k];
    end

    pixel_band_deserializer_reg #(.WIDTH(WIDTH)) u_fill (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .d    (in_data),
      .q    (fill_q[k])
    );

    pixel_band_deserializer_reg #(.WIDTH(WIDTH)) u_out (
      .clk  (clk),
      .rst  (rst),
      .load (xfer),
      .d    (od),
      .q    (out_data[k*WIDTH +: WIDTH])
    );
  end

`else

  assign in_ready  = rst && (state == FILL);
  assign out_valid = (state == FULL);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    if (clear) begin
      state_nx = FILL;
      idx_nx   = '0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept) begin
            idx_nx = last ? '0 : idx + 1'b1;
            if (last) state_nx = FULL;
          end
        end
        FULL: begin
          if (out_ready) state_nx = FILL;
        end
        default: state_nx = FILL;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_BANDS; k++) begin : g_slot
    pixel_band_deserializer_reg #(.WIDTH(WIDTH)) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .d    (in_data),
      .q    (out_data[k*WIDTH +: WIDTH])
    );
  end

`endif

endmodule

// File: tb/tb_pixel_band_deserializer.sv
// Self-checking bench for pixel_band_deserializer (default single bank).
// Table vectors, hand sequences and a randomized queue-based model.
module tb_pixel_band_deserializer;

  localparam int W  = 8;
  localparam int NB = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [NB*W-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] pixel_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pixel_band_deserializer #(
    .WIDTH(W), .NUM_BANDS(NB), .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pixel_cnt (pixel_cnt)
  );

  typedef struct {
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         clr;
    logic         ev;
    logic         eir;
    logic [31:0]  edata;
    logic [1:0]   ecnt;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(
    input logic iv, input logic [7:0] d,
    input logic ordy, input logic clr,
    input logic ev, input logic eir,
    input logic [31:0] edata, input logic [1:0] ecnt
  );
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy; v.clr = clr;
    v.ev = ev; v.eir = eir; v.edata = edata; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic check(
    input string name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic band(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  // Randomized model state
  logic [7:0]  mq[$];
  logic        mfull;
  logic [31:0] mpix;
  logic [1:0]  mcnt;
  logic [1:0]  ec;

  initial begin
    rst = 1'b0; clear = 1'b0; in_data = '0;
    in_valid = 1'b0; out_ready = 1'b0;

    tbl[0]  = mk(1, 8'h11, 0, 0, 0, 1, 32'h0, 2'd0);
    tbl[1]  = mk(1, 8'h22, 0, 0, 0, 1, 32'h0, 2'd0);
    tbl[2]  = mk(1, 8'h33, 0, 0, 0, 1, 32'h0, 2'd0);
    tbl[3]  = mk(1, 8'h44, 0, 0, 1, 0, 32'h44332211, 2'd0);
    tbl[4]  = mk(1, 8'h55, 0, 0, 1, 0, 32'h44332211, 2'd0);
    tbl[5]  = mk(0, 8'h00, 1, 0, 0, 1, 32'h0, 2'd1);
    tbl[6]  = mk(1, 8'hB1, 0, 0, 0, 1, 32'h0, 2'd1);
    tbl[7]  = mk(1, 8'hB2, 0, 0, 0, 1, 32'h0, 2'd1);
    tbl[8]  = mk(1, 8'hB3, 0, 1, 0, 1, 32'h0, 2'd1);
    tbl[9]  = mk(1, 8'hA1, 0, 0, 0, 1, 32'h0, 2'd1);
    tbl[10] = mk(1, 8'hA2, 0, 0, 0, 1, 32'h0, 2'd1);
    tbl[11] = mk(1, 8'hA3, 0, 0, 0, 1, 32'h0, 2'd1);
    tbl[12] = mk(1, 8'hA4, 0, 0, 1, 0, 32'hA4A3A2A1, 2'd1);
    tbl[13] = mk(0, 8'h00, 1, 1, 0, 1, 32'h0, 2'd1);
    tbl[14] = mk(1, 8'hC1, 0, 0, 0, 1, 32'h0, 2'd1);
    tbl[15] = mk(1, 8'hC2, 0, 0, 0, 1, 32'h0, 2'd1);
    tbl[16] = mk(1, 8'hC3, 0, 0, 0, 1, 32'h0, 2'd1);
    tbl[17] = mk(1, 8'hC4, 0, 0, 1, 0, 32'hC4C3C2C1, 2'd1);
    tbl[18] = mk(0, 8'h00, 1, 0, 0, 1, 32'h0, 2'd2);

    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_pixel_cnt", 64'(pixel_cnt), 64'd0);
    rst = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 19; i++) begin
      in_valid  = tbl[i].iv;
      in_data   = tbl[i].d;
      out_ready = tbl[i].ordy;
      clear     = tbl[i].clr;
      tick();
      check($sformatf("v%0d_out_valid", i),
            64'(out_valid), 64'(tbl[i].ev));
      check($sformatf("v%0d_in_ready", i),
            64'(in_ready), 64'(tbl[i].eir));
      check($sformatf("v%0d_pixel_cnt", i),
            64'(pixel_cnt), 64'(tbl[i].ecnt));
      if (tbl[i].ev)
        check($sformatf("v%0d_out_data", i),
              64'(out_data), 64'(tbl[i].edata));
    end
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;

    // Counter wrap over four more pixels
    ec = 2'd2;
    for (int p = 0; p < 4; p++) begin
      logic [31:0] px;
      px = '0;
      for (int b = 0; b < 4; b++) begin
        logic [7:0] s;
        s = 8'($urandom);
        px[b*8 +: 8] = s;
        band(s);
      end
      check($sformatf("wrap%0d_valid", p), 64'(out_valid), 64'd1);
      check($sformatf("wrap%0d_data", p), 64'(out_data), 64'(px));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      ec = ec + 2'd1;
      check($sformatf("wrap%0d_cnt", p), 64'(pixel_cnt), 64'(ec));
    end

    // Async reset mid-pixel
    band(8'h01); band(8'h02); band(8'h03);
    rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_pixel_cnt", 64'(pixel_cnt), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    band(8'hD1); band(8'hD2); band(8'hD3);
    check("arst_partial", 64'(out_valid), 64'd0);
    band(8'hD4);
    check("arst_full", 64'(out_valid), 64'd1);
    check("arst_data", 64'(out_data), 64'h00000000D4D3D2D1);
    out_ready = 1'b1;
    tick();
    check("arst_cnt", 64'(pixel_cnt), 64'd1);

    // Randomized traffic against a queue model, out_ready held high
    mq.delete();
    mfull = 1'b0;
    mpix  = '0;
    mcnt  = 2'd1;
    for (int c = 0; c < 400; c++) begin
      logic iv;
      logic [7:0] d;
      check("rnd_in_ready", 64'(in_ready), 64'(!mfull));
      check("rnd_out_valid", 64'(out_valid), 64'(mfull));
      check("rnd_pixel_cnt", 64'(pixel_cnt), 64'(mcnt));
      if (mfull)
        check("rnd_out_data", 64'(out_data), 64'(mpix));
      iv = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      in_valid = iv;
      in_data  = d;
      if (mfull) begin
        mfull = 1'b0;
        mcnt  = mcnt + 2'd1;
      end else if (iv) begin
        mq.push_back(d);
        if (mq.size() == NB) begin
          mpix  = {mq[3], mq[2], mq[1], mq[0]};
          mq.delete();
          mfull = 1'b1;
        end
      end
      tick();
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
